// File: rtl/temp_pkg.sv
// Shared types and default thresholds for the temperature threshold detector.
package temp_pkg;

   typedef enum logic [1:0] {
      NORM  = 2'd0,
      WARM  = 2'd1,
      HOT   = 2'd2,
      FAULT = 2'd3
   } temp_state_e;

   localparam int unsigned DEF_T_LO = 36;
   localparam int unsigned DEF_T_HI = 38;
   localparam int unsigned DEF_HYST = 1;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear (priority over enable) that sticks at all-ones.
module sat_counter #(
   parameter int unsigned W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] cnt
);

   logic [W-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else if (clr) begin
         cnt_q <= '0;
      end else if (en && (cnt_q != {W{1'b1}})) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/temp_threshold_detect.sv
// Debounced, hysteretic temperature level flags with a sensor-loss watchdog.
// On sensor loss both flags are forced high so both fans run.
module temp_threshold_detect
   import temp_pkg::*;
#(
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned T_LO    = DEF_T_LO,
   parameter int unsigned T_HI    = DEF_T_HI,
   parameter int unsigned HYST    = DEF_HYST,
   parameter int unsigned DEB_N   = 4,
   parameter int unsigned TIMEOUT = 1000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] temp_data,
   input  logic              temp_valid,
   output logic              temp36,
   output logic              temp38,
   output logic              sensor_fault
);

   localparam int unsigned DEB_W = $clog2(DEB_N + 1);
   localparam int unsigned WD_W  = $clog2(TIMEOUT + 1);

   localparam logic [DATA_W-1:0] LO_SET = DATA_W'(T_LO);
   localparam logic [DATA_W-1:0] HI_SET = DATA_W'(T_HI);
   localparam logic [DATA_W-1:0] LO_REL = DATA_W'(T_LO - HYST);
   localparam logic [DATA_W-1:0] HI_REL = DATA_W'(T_HI - HYST);
   localparam logic [DEB_W-1:0]  DEB_LAST = DEB_W'(DEB_N - 1);
   localparam logic [WD_W-1:0]   WD_LIMIT = WD_W'(TIMEOUT);

   if (T_HI <= T_LO) begin : g_chk_thr
      $error("T_HI must be greater than T_LO");
   end
   if (HYST > T_LO) begin : g_chk_hyst
      $error("HYST must not exceed T_LO");
   end
   if (DEB_N < 1) begin : g_chk_deb
      $error("DEB_N must be at least 1");
   end
   if (TIMEOUT < 2) begin : g_chk_to
      $error("TIMEOUT must be at least 2");
   end

   temp_state_e state_q, state_d;

   logic [DEB_W-1:0] up_cnt, dn_cnt;
   logic [WD_W-1:0]  wd_cnt;
   logic             up_cond, dn_cond, up_last, dn_last, wd_hit, state_chg;
   logic             up_clr, dn_clr, wd_clr;

   // In FAULT every valid sample counts toward recovery, whatever its value.
   always_comb begin
      up_cond = 1'b0;
      dn_cond = 1'b0;
      unique case (state_q)
         NORM:  up_cond = (temp_data >= LO_SET);
         WARM: begin
            up_cond = (temp_data >= HI_SET);
            dn_cond = (temp_data < LO_REL);
         end
         HOT:   dn_cond = (temp_data < HI_REL);
         FAULT: up_cond = 1'b1;
         default: ;
      endcase
   end

   assign up_last = temp_valid && up_cond && (up_cnt == DEB_LAST);
   assign dn_last = temp_valid && dn_cond && (dn_cnt == DEB_LAST);
   assign wd_hit  = (state_q != FAULT) && (wd_cnt >= WD_LIMIT);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= NORM;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (wd_hit) begin
         state_d = FAULT;
      end else if (up_last) begin
         unique case (state_q)
            NORM:  state_d = WARM;
            WARM:  state_d = HOT;
            FAULT: begin
               if (temp_data >= HI_SET) begin
                  state_d = HOT;
               end else if (temp_data >= LO_SET) begin
                  state_d = WARM;
               end else begin
                  state_d = NORM;
               end
            end
            default: ;
         endcase
      end else if (dn_last) begin
         unique case (state_q)
            WARM:    state_d = NORM;
            HOT:     state_d = WARM;
            default: ;
         endcase
      end
   end

   always_comb begin
      temp36       = 1'b0;
      temp38       = 1'b0;
      sensor_fault = 1'b0;
      unique case (state_q)
         NORM: ;
         WARM: temp36 = 1'b1;
         HOT: begin
            temp36 = 1'b1;
            temp38 = 1'b1;
         end
         FAULT: begin
            temp36       = 1'b1;
            temp38       = 1'b1;
            sensor_fault = 1'b1;
         end
         default: ;
      endcase
   end

   assign state_chg = (state_d != state_q);
   assign up_clr    = state_chg || (temp_valid && !up_cond);
   assign dn_clr    = state_chg || (temp_valid && !dn_cond);
   assign wd_clr    = temp_valid || wd_hit || (state_q == FAULT);

   sat_counter #(.W(DEB_W)) u_up_cnt (
      .clk (clk),
      .rst (rst),
      .clr (up_clr),
      .en  (temp_valid && up_cond),
      .cnt (up_cnt)
   );

   sat_counter #(.W(DEB_W)) u_dn_cnt (
      .clk (clk),
      .rst (rst),
      .clr (dn_clr),
      .en  (temp_valid && dn_cond),
      .cnt (dn_cnt)
   );

   sat_counter #(.W(WD_W)) u_wd_cnt (
      .clk (clk),
      .rst (rst),
      .clr (wd_clr),
      .en  (1'b1),
      .cnt (wd_cnt)
   );

endmodule
